// File: rtl/beer_pkg.sv
// beer_pkg
// Shared definitions for the beer tap / glass sensor slice:
//   - tap state_display encodings (OFF, FOAM, BEER)
//   - beer_level codes (LVL_NONE, LVL_LOW, LVL_POUR, LVL_FULL)
//   - glass sensor FSM state encoding
//   - HIGH/LOW single-bit constants
//   - levelFor(): maps a fill count onto the beer_level code
package beer_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    FOAM = 2'd1,
    BEER = 2'd2
  } tap_state_e;

  typedef enum logic [1:0] {
    LVL_NONE = 2'd0,
    LVL_LOW  = 2'd1,
    LVL_POUR = 2'd2,
    LVL_FULL = 2'd3
  } level_e;

  typedef enum logic [1:0] {
    S_NOGLASS = 2'd0,
    S_PRESENT = 2'd1,
    S_FULL    = 2'd2,
    S_SPILL   = 2'd3
  } sensor_state_e;

  // Level code for a glass that is present: below the head threshold the
  // glass reads low, below the full threshold it is in the pour band.
  function automatic level_e levelFor(input int fill, input int foamTh, input int fullTh);
    if (fill < foamTh)      return LVL_LOW;
    else if (fill < fullTh) return LVL_POUR;
    else                    return LVL_FULL;
  endfunction

endpackage

// File: rtl/next_strobe_gen.sv
// next_strobe_gen
// Free-running square-wave stepping strobe for the beer tap.
// Ports:
//   i_clk   : system clock
//   i_reset : synchronous active-low reset
//   o_next  : registered strobe, high for the first STEP_DIV/2 divider
//             counts of each period; first rising edge on the first clock
//             after reset is released
module next_strobe_gen
  import beer_pkg::*;
#(
  parameter int STEP_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_next
);

  localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic             r_next;

  // The strobe is registered from the divider value, so during reset it is
  // low and it rises on the very first clock after release.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_div  <= '0;
      r_next <= LOW;
    end else begin
      r_div  <= (r_div == DIV_W'(STEP_DIV - 1)) ? '0 : r_div + 1'b1;
      r_next <= (r_div < DIV_W'(STEP_DIV / 2)) ? HIGH : LOW;
    end
  end

  assign o_next = r_next;

endmodule

// File: rtl/glass_level_sensor.sv
// glass_level_sensor
// Models the glass under the beer tap: integrates poured volume into a
// saturating fill counter, quantises it into the 2-bit beer_level code,
// generates the tap's stepping strobe and raises a sticky spill flag.
// Optional feature: define GLASS_DEBOUNCE_EN to debounce glass_present
// over DEB_CYC cycles; undefined, glass_present is used directly.
// Ports:
//   i_clk           : system clock
//   i_reset         : synchronous active-low reset
//   i_glass_present : glass detected under tap
//   i_beer          : tap beer output
//   i_state_display : tap state (0 off, 1 foam, 2 beer, 3 treated as off)
//   o_beer_level    : 0 no glass, 1 low, 2 pour band, 3 full
//   o_next          : stepping strobe to tap
//   o_fill          : current fill count
//   o_spill         : sticky spill flag
module glass_level_sensor
  import beer_pkg::*;
#(
  parameter int FILL_W    = 8,
  parameter int FOAM_RATE = 1,
  parameter int BEER_RATE = 4,
  parameter int FOAM_TH   = 16,
  parameter int FULL_TH   = 200,
  parameter int SPILL_CYC = 8,
  parameter int STEP_DIV  = 4
`ifdef GLASS_DEBOUNCE_EN
  ,
  parameter int DEB_CYC   = 4
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_glass_present,
  input  logic              i_beer,
  input  logic [1:0]        i_state_display,
  output logic [1:0]        o_beer_level,
  output logic              o_next,
  output logic [FILL_W-1:0] o_fill,
  output logic              o_spill
);

  localparam int CNT_W = $clog2(SPILL_CYC + 1);

  logic              w_present;
  logic [FILL_W:0]   w_add;
  logic [FILL_W:0]   w_sum;
  logic [FILL_W-1:0] w_fillSat;

  sensor_state_e     r_state;
  logic [FILL_W-1:0] r_fill;
  logic              r_spill;
  logic [CNT_W-1:0]  r_spillCnt;
  logic [1:0]        r_level;

  next_strobe_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_next (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_next  (o_next)
  );

`ifdef GLASS_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYC + 1);

  logic             r_present;
  logic [DEB_W-1:0] r_debCnt;

  // Presence only flips after DEB_CYC consecutive samples that disagree
  // with it; any agreeing sample restarts the count.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_present <= LOW;
      r_debCnt  <= '0;
    end else if (i_glass_present == r_present) begin
      r_debCnt <= '0;
    end else if (r_debCnt == DEB_W'(DEB_CYC - 1)) begin
      r_present <= i_glass_present;
      r_debCnt  <= '0;
    end else begin
      r_debCnt <= r_debCnt + 1'b1;
    end
  end

  assign w_present = r_present;
`else
  assign w_present = i_glass_present;
`endif

  // Pour increment and saturating sum; the extra carry bit detects
  // overflow so the fill clamps at all-ones instead of wrapping.
  // state_display=3 falls through to a zero increment like OFF.
  always_comb begin
    w_add = '0;
    if (i_beer) begin
      w_add = (FILL_W + 1)'(BEER_RATE);
    end else if (tap_state_e'(i_state_display) == FOAM) begin
      w_add = (FILL_W + 1)'(FOAM_RATE);
    end
    w_sum     = {1'b0, r_fill} + w_add;
    w_fillSat = w_sum[FILL_W] ? '1 : w_sum[FILL_W-1:0];
  end

  // Sensor FSM with registered fill, spill and level. Glass removal wins
  // over any pour in the same cycle. The level is computed from the fill
  // register before this edge's update, so it lags the fill by one cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= S_NOGLASS;
      r_fill     <= '0;
      r_spill    <= LOW;
      r_spillCnt <= '0;
      r_level    <= LVL_NONE;
    end else if (!w_present) begin
      r_state    <= S_NOGLASS;
      r_fill     <= '0;
      r_spill    <= LOW;
      r_spillCnt <= '0;
      r_level    <= LVL_NONE;
    end else begin
      r_level <= levelFor(int'(r_fill), FOAM_TH, FULL_TH);
      case (r_state)
        S_NOGLASS: begin
          r_state <= S_PRESENT;
          r_fill  <= '0;
        end
        S_PRESENT: begin
          r_fill <= w_fillSat;
          if (int'(w_fillSat) >= FULL_TH) r_state <= S_FULL;
        end
        S_FULL: begin
          r_fill <= w_fillSat;
          if (i_beer) begin
            r_spillCnt <= r_spillCnt + 1'b1;
            if (r_spillCnt == CNT_W'(SPILL_CYC - 1)) begin
              r_state <= S_SPILL;
              r_spill <= HIGH;
            end
          end else begin
            r_spillCnt <= '0;
          end
        end
        S_SPILL: begin
          r_fill  <= w_fillSat;
          r_spill <= HIGH;
        end
        default: r_state <= S_NOGLASS;
      endcase
    end
  end

  assign o_beer_level = r_level;
  assign o_fill       = r_fill;
  assign o_spill      = r_spill;

endmodule
